collision_scorer: RTL

- Pixel-coincidence collision detector and game-state accumulator. Sits between the sprite generators and the top-level colour mux.
- Consumes the per-pixel graphics flags (laser, alien, bomb, cannon) plus the alien row/column under the beam.
- Owns the alive matrix, score and lives; returns hit_alien to cannon_laser and alive_matrix to alien_formation.
- Latches collisions during the visible scan and commits all updates once per frame, at the vsync rising edge.

---
 rtl/chipinvaders_pkg.sv | 19 +
 rtl/score_accumulator.sv | 38 +++
 rtl/collision_scorer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/chipinvaders_pkg.sv
// Shared constants and types for the collision/score path.
package chipinvaders_pkg;

  localparam int unsigned NUM_ROWS_DEF        = 5;
  localparam int unsigned NUM_COLUMNS_DEF     = 8;
  localparam int unsigned START_LIVES_DEF     = 3;
  localparam int unsigned SCORE_MAX_DEF       = 9999;
  localparam int unsigned ROW_POINTS_STEP_DEF = 10;
  localparam int unsigned SCORE_W             = 14;
  localparam int unsigned LIVES_W             = 2;

  typedef enum logic {
    SCAN   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/score_accumulator.sv
// Saturating score register; adds the row-weighted value of one kill per add_en.
module score_accumulator
  import chipinvaders_pkg::*;
#(
  parameter int unsigned NUM_ROWS        = NUM_ROWS_DEF,
  parameter int unsigned ROW_POINTS_STEP = ROW_POINTS_STEP_DEF,
  parameter int unsigned SCORE_MAX       = SCORE_MAX_DEF,
  localparam int unsigned ROW_W          = $clog2(NUM_ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add_en,
  input  logic [ROW_W-1:0] row,
  output score_t           score
);

  score_t      score_q, score_d;
  int unsigned sum;

  always_comb begin
    sum     = 32'(score_q) + ROW_POINTS_STEP * (NUM_ROWS - 32'(row));
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (add_en) begin
      score_d = (sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) score_q <= '0;
    else        score_q <= score_d;
  end

  assign score = score_q;

endmodule

// File: rtl/collision_scorer.sv
// Latches laser/alien and bomb/cannon coincidences during the scan and commits
// alive matrix, score and lives once per frame on the vsync rising edge.
module collision_scorer
  import chipinvaders_pkg::*;
#(
  parameter int unsigned NUM_ROWS        = NUM_ROWS_DEF,
  parameter int unsigned NUM_COLUMNS     = NUM_COLUMNS_DEF,
  parameter int unsigned START_LIVES     = START_LIVES_DEF,
  parameter int unsigned SCORE_MAX       = SCORE_MAX_DEF,
  parameter int unsigned ROW_POINTS_STEP = ROW_POINTS_STEP_DEF,
  localparam int unsigned ROW_W          = $clog2(NUM_ROWS),
  localparam int unsigned COL_W          = $clog2(NUM_COLUMNS),
  localparam int unsigned NUM_ALIENS     = NUM_ROWS * NUM_COLUMNS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  display_on,
  input  logic                  enable,
  input  logic                  reset_game,
  input  logic                  laser_gfx,
  input  logic                  alien_pixel,
  input  logic [ROW_W-1:0]      alien_row,
  input  logic [COL_W-1:0]      alien_col,
  input  logic                  bomb_gfx,
  input  logic                  cannon_gfx,
  output logic [NUM_ALIENS-1:0] alive_matrix,
  output logic                  hit_alien,
  output logic                  kill_valid,
  output logic [ROW_W-1:0]      kill_row,
  output logic [COL_W-1:0]      kill_col,
  output logic [SCORE_W-1:0]    score,
  output logic [LIVES_W-1:0]    lives,
  output logic                  game_over,
  output logic                  wave_clear
);

  localparam int unsigned IDX_W = $clog2(NUM_ALIENS);

  state_e                state_q, state_d;
  logic                  vsync_q, vsync_d;
  logic [NUM_ALIENS-1:0] alive_q, alive_d, alive_after;
  logic                  alien_pend_q, alien_pend_d;
  logic                  cannon_pend_q, cannon_pend_d;
  logic [ROW_W-1:0]      pend_row_q, pend_row_d;
  logic [COL_W-1:0]      pend_col_q, pend_col_d;
  logic                  hit_q, hit_d;
  logic                  kill_valid_q, kill_valid_d;
  logic [ROW_W-1:0]      kill_row_q, kill_row_d;
  logic [COL_W-1:0]      kill_col_q, kill_col_d;
  logic [LIVES_W-1:0]    lives_q, lives_d;
  logic                  wave_clear_q, wave_clear_d;

  logic                  commit_tick;
  logic [IDX_W-1:0]      beam_idx, pend_idx;
  logic                  alive_at_beam;
  logic                  score_add;

  assign commit_tick = vsync & ~vsync_q;
  assign beam_idx    = IDX_W'(32'(alien_row) * NUM_COLUMNS + 32'(alien_col));
  assign pend_idx    = IDX_W'(32'(pend_row_q) * NUM_COLUMNS + 32'(pend_col_q));
  // Stale alien_pixel over a dead (or out-of-range) slot must never latch.
  assign alive_at_beam = (32'(alien_row) < NUM_ROWS) && (32'(alien_col) < NUM_COLUMNS)
                         && alive_q[beam_idx];

  always_comb begin
    state_d       = state_q;
    vsync_d       = vsync;
    alive_d       = alive_q;
    alive_after   = alive_q;
    alien_pend_d  = alien_pend_q;
    cannon_pend_d = cannon_pend_q;
    pend_row_d    = pend_row_q;
    pend_col_d    = pend_col_q;
    hit_d         = hit_q;
    kill_valid_d  = 1'b0;
    kill_row_d    = kill_row_q;
    kill_col_d    = kill_col_q;
    lives_d       = lives_q;
    wave_clear_d  = wave_clear_q;
    score_add     = 1'b0;

    case (state_q)
      SCAN: begin
        if (commit_tick) state_d = COMMIT;
        if (enable && display_on && laser_gfx && alien_pixel && !alien_pend_q && alive_at_beam) begin
          alien_pend_d = 1'b1;
          pend_row_d   = alien_row;
          pend_col_d   = alien_col;
        end
        if (enable && display_on && bomb_gfx && cannon_gfx) cannon_pend_d = 1'b1;
      end
      COMMIT: begin
        state_d       = SCAN;
        alien_pend_d  = 1'b0;
        cannon_pend_d = 1'b0;
        hit_d         = alien_pend_q;
        if (alien_pend_q) begin
          alive_after[pend_idx] = 1'b0;
          kill_valid_d          = 1'b1;
          kill_row_d            = pend_row_q;
          kill_col_d            = pend_col_q;
          score_add             = 1'b1;
        end
        if (cannon_pend_q && (lives_q != '0)) lives_d = lives_q - LIVES_W'(1);
        // A cleared wave stays empty for one frame, then the next commit refills it.
        if (wave_clear_q) begin
          alive_d      = '1;
          wave_clear_d = 1'b0;
        end else begin
          alive_d      = alive_after;
          wave_clear_d = (alive_after == '0);
        end
      end
      default: state_d = SCAN;
    endcase

    if (reset_game) begin
      alive_d       = '1;
      lives_d       = LIVES_W'(START_LIVES);
      alien_pend_d  = 1'b0;
      cannon_pend_d = 1'b0;
      hit_d         = 1'b0;
      wave_clear_d  = 1'b0;
      kill_valid_d  = 1'b0;
      score_add     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= SCAN;
      vsync_q       <= 1'b0;
      alive_q       <= '1;
      alien_pend_q  <= 1'b0;
      cannon_pend_q <= 1'b0;
      pend_row_q    <= '0;
      pend_col_q    <= '0;
      hit_q         <= 1'b0;
      kill_valid_q  <= 1'b0;
      kill_row_q    <= '0;
      kill_col_q    <= '0;
      lives_q       <= LIVES_W'(START_LIVES);
      wave_clear_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      alive_q       <= alive_d;
      alien_pend_q  <= alien_pend_d;
      cannon_pend_q <= cannon_pend_d;
      pend_row_q    <= pend_row_d;
      pend_col_q    <= pend_col_d;
      hit_q         <= hit_d;
      kill_valid_q  <= kill_valid_d;
      kill_row_q    <= kill_row_d;
      kill_col_q    <= kill_col_d;
      lives_q       <= lives_d;
      wave_clear_q  <= wave_clear_d;
    end
  end

  score_accumulator #(
    .NUM_ROWS        (NUM_ROWS),
    .ROW_POINTS_STEP (ROW_POINTS_STEP),
    .SCORE_MAX       (SCORE_MAX)
  ) u_score (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (reset_game),
    .add_en (score_add),
    .row    (pend_row_q),
    .score  (score)
  );

  assign alive_matrix = alive_q;
  assign hit_alien    = hit_q;
  assign kill_valid   = kill_valid_q;
  assign kill_row     = kill_row_q;
  assign kill_col     = kill_col_q;
  assign lives        = lives_q;
  assign wave_clear   = wave_clear_q;
  assign game_over    = (lives_q == '0);

endmodule
